xgmii_tx_arb: RTL and testbench
===============================

# xgmii_tx_arb

Frame-level arbiter that shares the 64-bit XGMII transmit interface between two frame sources, such as the UDP test-frame generator and a reply/echo engine. It grants the link per whole frame using round-robin and passes the granted source's words to the link with one cycle of registered latency. Between frames it enforces a minimum idle gap. It also guards against sources that never start or never terminate a frame. It sits directly in front of the XGMII PHY transmit pins in the app layer.

## Interface
- IFG_CYCLES, 2, idle cycles forced after every frame; legal range is 1 or more.
- MAX_WORDS, 190, maximum number of words from the start word to the terminate word before the frame is aborted.
- START_TIMEOUT, 16, number of cycles a granted source may take to present its start word.
- xgmii_clk  in  1  the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- en  in  2  per-source enable; bit n masks sN_req.
- s0_req, s1_req  in  1  the source has a frame ready; held level until granted.
- s0_gnt, s1_gnt  out  1  registered, one-hot grant, held for the whole frame.
- s0_txd, s1_txd  in  64  source XGMII data, lane 0 = bits [7:0].
- s0_txc, s1_txc  in  8  source XGMII control, bit n qualifies lane n.
- xgmii_txd  out  64  registered link data.
- xgmii_txc  out  8  registered link control.
- frame_cnt0, frame_cnt1  out  16  count of cleanly terminated frames per source; wraps.
- abort_cnt  out  8  count of MAX_WORDS aborts; saturates at 0xFF.
- busy  out  1  high when the state is not IDLE.

## Operation
- Idle word: txc = 0xFF, txd = 0x0707070707070707.
- Start word: txc[0] = 1 and txd[7:0] = 0xFB.
- Terminate: any lane n with txc[n] = 1 and txd[8n+7:8n] = 0xFD.
- Abort word: txc = 0xFF, txd = 0x07070707070707FD (terminate in lane 0).
- States: IDLE, WAIT_SOF, SEND, GAP.
- IDLE:
  - Output idle.
  - Effective request is reqN = sN_req & en[N].
  - If any reqN is set, grant by round-robin: the source that was not served last wins when both request. The `last` pointer resets to 1, so source 0 wins the first tie.
  - Set sN_gnt, update `last`, load the timeout counter, and go to WAIT_SOF.
- WAIT_SOF:
  - Output idle; source words that arrive before the start word are discarded.
  - When the granted source presents a start word, register it to the output, clear the word counter to 1, and go to SEND.
  - If START_TIMEOUT cycles pass without a start word: clear the grant, output idle, go to IDLE, and leave `last` pointing at the timed-out source.
- SEND:
  - Pass through the granted source's word each cycle and increment the word counter.
  - On a terminate word: pass it through, increment that source's frame_cnt, clear the grant, load the gap counter with IFG_CYCLES-1, and go to GAP.
  - If the word counter reaches MAX_WORDS with no terminate: output the abort word instead of the source word, increment abort_cnt, clear the grant, and go to GAP.
- GAP:
  - Output idle.
  - When the gap counter is 0, go to IDLE; otherwise decrement it.
  - GAP lasts exactly IFG_CYCLES cycles.
- Deasserting sN_req or en[N] after the grant has no effect; the grant is held until terminate, abort, or timeout.
- The counter widths are fixed. frame_cnt wraps from 0xFFFF to 0. abort_cnt holds at 0xFF.

## Timing
- Reset values:
  - xgmii_txd = 0x0707070707070707, xgmii_txc = 0xFF.
  - s0_gnt = s1_gnt = 0, busy = 0.
  - All counters are 0, state is IDLE, last = 1.
- Reset during a frame: the output is idle on the next cycle and no terminate word is emitted. A truncated frame on the link is acceptable.
- Grant and data latency:
  - A request seen in IDLE at cycle t gives gnt high from t+1.
  - A source word present at cycle k appears on xgmii_* at k+1.
- Frame end:
  - For a terminate seen at cycle k, gnt is low from k+1.
  - Idle words are output from k+2 through k+1+IFG_CYCLES.
  - The state is IDLE at k+1+IFG_CYCLES and the earliest next grant is at k+2+IFG_CYCLES.
- The word containing the terminate, including any data bytes in lanes below it, is always forwarded unchanged.

## Test plan
- Single frame: s0 requests; the source sends FB, 7 data words, then FD in lane 4. The link matches the source stream delayed by 1 cycle, s0_gnt falls on the cycle after FD, 2 idle cycles follow, and frame_cnt0 = 1.
- Contention: both sources request continuously with en = 2'b11. Grants alternate s0, s1, s0, s1 starting with s0. After 4 frames, frame_cnt0 = frame_cnt1 = 2.
- Enable mask: en = 2'b10 with both requesting. Only s1 is granted; frame_cnt0 stays 0.
- Start timeout: s0 is granted but never sends FB. After 16 cycles s0_gnt drops, the output stays idle throughout, and a pending s1 is granted next.
- Runaway frame: s1 sends FB followed by endless data. Word 190 on the link is the abort word 0x07070707070707FD with txc = 0xFF, abort_cnt = 1, and frame_cnt1 = 0.
- Reset during SEND: assert sys_rst for 1 cycle. The next output is the idle word, gnt = 0, busy = 0, all counters are 0, and the next tie is granted to s0.

Source files
------------

// File: rtl/xgmii_tx_arb.sv
// Frame-granular round-robin arbiter that shares one XGMII transmit link between two sources,
// with a registered output stage, a forced inter-frame gap and start/length watchdogs.
module xgmii_tx_arb #(
  parameter int IFG_CYCLES    = 2,
  parameter int MAX_WORDS     = 190,
  parameter int START_TIMEOUT = 16
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst,
  input  logic [1:0]  en,
  input  logic        s0_req,
  input  logic        s1_req,
  output logic        s0_gnt,
  output logic        s1_gnt,
  input  logic [63:0] s0_txd,
  input  logic [7:0]  s0_txc,
  input  logic [63:0] s1_txd,
  input  logic [7:0]  s1_txc,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic [7:0]  abort_cnt,
  output logic        busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] SEND     = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_TXC  = 8'hFF;
  localparam logic [63:0] ABORT_TXD = 64'h07070707070707FD;

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int TOW = $clog2(START_TIMEOUT + 1);
  localparam int GW  = $clog2(IFG_CYCLES + 1);

  // word_cnt holds the number of the word last forwarded, so the abort replaces word MAX_WORDS.
  localparam logic [WCW-1:0] WORD_LAST = WCW'(MAX_WORDS - 1);
  localparam logic [TOW-1:0] TMO_LOAD  = TOW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LOAD  = GW'(IFG_CYCLES - 1);

  logic [1:0]     state;
  logic           last;
  logic [WCW-1:0] word_cnt;
  logic [TOW-1:0] tmo_cnt;
  logic [GW-1:0]  gap_cnt;

  logic        req0;
  logic        req1;
  logic        pick1;
  logic [63:0] cur_txd;
  logic [7:0]  cur_txc;
  logic        is_sof;
  logic        is_term;

  assign req0 = s0_req & en[0];
  assign req1 = s1_req & en[1];
  // On a tie the source that was not served last wins.
  assign pick1 = req1 & (~req0 | ~last);

  assign cur_txd = s1_gnt ? s1_txd : s0_txd;
  assign cur_txc = s1_gnt ? s1_txc : s0_txc;
  assign is_sof  = cur_txc[0] && (cur_txd[7:0] == 8'hFB);
  assign busy    = (state != IDLE);

  always_comb begin
    is_term = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cur_txc[i] && (cur_txd[8*i +: 8] == 8'hFD)) is_term = 1'b1;
    end
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      s0_gnt     <= 1'b0;
      s1_gnt     <= 1'b0;
      word_cnt   <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      frame_cnt0 <= 16'd0;
      frame_cnt1 <= 16'd0;
      abort_cnt  <= 8'd0;
      xgmii_txd  <= IDLE_TXD;
      xgmii_txc  <= IDLE_TXC;
    end else begin
      case (state)
        IDLE: begin
          xgmii_txd <= IDLE_TXD;
          xgmii_txc <= IDLE_TXC;
          if (req0 | req1) begin
            s0_gnt  <= ~pick1;
            s1_gnt  <= pick1;
            last    <= pick1;
            tmo_cnt <= TMO_LOAD;
            state   <= WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (is_sof) begin
            xgmii_txd <= cur_txd;
            xgmii_txc <= cur_txc;
            word_cnt  <= WCW'(1);
            state     <= SEND;
          end else begin
            xgmii_txd <= IDLE_TXD;
            xgmii_txc <= IDLE_TXC;
            if (tmo_cnt == '0) begin
              s0_gnt <= 1'b0;
              s1_gnt <= 1'b0;
              state  <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt - TOW'(1);
            end
          end
        end
        SEND: begin
          word_cnt <= word_cnt + WCW'(1);
          if (is_term) begin
            xgmii_txd <= cur_txd;
            xgmii_txc <= cur_txc;
            if (s1_gnt) frame_cnt1 <= frame_cnt1 + 16'd1;
            else        frame_cnt0 <= frame_cnt0 + 16'd1;
            s0_gnt  <= 1'b0;
            s1_gnt  <= 1'b0;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else if (word_cnt == WORD_LAST) begin
            xgmii_txd <= ABORT_TXD;
            xgmii_txc <= IDLE_TXC;
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
            s0_gnt  <= 1'b0;
            s1_gnt  <= 1'b0;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else begin
            xgmii_txd <= cur_txd;
            xgmii_txc <= cur_txc;
          end
        end
        GAP: begin
          xgmii_txd <= IDLE_TXD;
          xgmii_txc <= IDLE_TXC;
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: begin
          xgmii_txd <= IDLE_TXD;
          xgmii_txc <= IDLE_TXC;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_tx_arb.sv
// Self-checking bench for xgmii_tx_arb: a cycle table for single frames plus
// directed sequences for contention, masking, timeouts, runaway frames and reset.
module tb_xgmii_tx_arb;

  localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_TXC  = 8'hFF;
  localparam logic [63:0] ABORT_TXD = 64'h07070707070707FD;
  localparam logic [63:0] SOF_TXD   = 64'hD5555555555555FB;
  localparam logic [63:0] TERM4_TXD = 64'h070707FDAABBCCDD;
  localparam logic [63:0] JUNK_TXD  = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] RUN_TXD   = 64'h0123456789ABCDEF;

  logic        xgmii_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  en;
  logic        s0_req, s1_req;
  logic        s0_gnt, s1_gnt;
  logic [63:0] s0_txd, s1_txd;
  logic [7:0]  s0_txc, s1_txc;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [15:0] frame_cnt0, frame_cnt1;
  logic [7:0]  abort_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        req0;
    logic [63:0] d0;
    logic [7:0]  c0;
    logic        egnt0;
    logic [63:0] etxd;
    logic [7:0]  etxc;
    logic        ebusy;
    logic [15:0] efc0;
  } vec_t;

  vec_t vec_q[$];

  xgmii_tx_arb #(.IFG_CYCLES(2), .MAX_WORDS(190), .START_TIMEOUT(16)) dut (
    .xgmii_clk (xgmii_clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .s0_req    (s0_req),
    .s1_req    (s1_req),
    .s0_gnt    (s0_gnt),
    .s1_gnt    (s1_gnt),
    .s0_txd    (s0_txd),
    .s0_txc    (s0_txc),
    .s1_txd    (s1_txd),
    .s1_txc    (s1_txc),
    .xgmii_txd (xgmii_txd),
    .xgmii_txc (xgmii_txc),
    .frame_cnt0(frame_cnt0),
    .frame_cnt1(frame_cnt1),
    .abort_cnt (abort_cnt),
    .busy      (busy)
  );

  always #5 xgmii_clk = ~xgmii_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge xgmii_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_src(input int s, input logic [63:0] d, input logic [7:0] c);
    if (s == 0) begin
      s0_txd = d;
      s0_txc = c;
    end else begin
      s1_txd = d;
      s1_txc = c;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    s0_req  = 1'b0;
    s1_req  = 1'b0;
    en      = 2'b11;
    set_src(0, IDLE_TXD, IDLE_TXC);
    set_src(1, IDLE_TXD, IDLE_TXC);
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 64 && who < 0; i++) begin
      step();
      if (s0_gnt)      who = 0;
      else if (s1_gnt) who = 1;
    end
  endtask

  // Drives SOF, ndata data words and a lane-4 terminate on a source already holding the grant.
  task automatic apply_stimulus(input int s, input int ndata);
    set_src(s, SOF_TXD, 8'h01);
    step();
    for (int i = 0; i < ndata; i++) begin
      set_src(s, 64'h1000000000000000 + 64'(i), 8'h00);
      step();
    end
    set_src(s, TERM4_TXD, 8'hF0);
    step();
    check_output($sformatf("gnt_drop_s%0d", s), 64'(s == 0 ? s0_gnt : s1_gnt), 64'd0);
    set_src(s, IDLE_TXD, IDLE_TXC);
  endtask

  task automatic add_row(input logic req0, input logic [63:0] d0, input logic [7:0] c0,
                         input logic egnt0, input logic [63:0] etxd, input logic [7:0] etxc,
                         input logic ebusy, input logic [15:0] efc0);
    vec_t v;
    v.req0 = req0; v.d0 = d0; v.c0 = c0; v.egnt0 = egnt0;
    v.etxd = etxd; v.etxc = etxc; v.ebusy = ebusy; v.efc0 = efc0;
    vec_q.push_back(v);
  endtask

  initial begin
    int who;
    int hi;
    logic idle_ok;

    // Row order: grant, junk before SOF, SOF, 7 data, lane-4 terminate, gap, then a second short frame.
    add_row(1'b1, IDLE_TXD, IDLE_TXC, 1'b1, IDLE_TXD, IDLE_TXC, 1'b1, 16'd0);
    add_row(1'b0, JUNK_TXD, 8'h00,    1'b1, IDLE_TXD, IDLE_TXC, 1'b1, 16'd0);
    add_row(1'b0, SOF_TXD,  8'h01,    1'b1, SOF_TXD,  8'h01,    1'b1, 16'd0);
    for (int i = 0; i < 7; i++)
      add_row(1'b0, 64'h0102030405060700 + 64'(i), 8'h00, 1'b1,
              64'h0102030405060700 + 64'(i), 8'h00, 1'b1, 16'd0);
    add_row(1'b0, TERM4_TXD, 8'hF0,   1'b0, TERM4_TXD, 8'hF0,   1'b1, 16'd1);
    add_row(1'b1, IDLE_TXD, IDLE_TXC, 1'b0, IDLE_TXD, IDLE_TXC, 1'b1, 16'd1);
    add_row(1'b1, IDLE_TXD, IDLE_TXC, 1'b0, IDLE_TXD, IDLE_TXC, 1'b0, 16'd1);
    add_row(1'b1, IDLE_TXD, IDLE_TXC, 1'b1, IDLE_TXD, IDLE_TXC, 1'b1, 16'd1);
    add_row(1'b0, SOF_TXD,  8'h01,    1'b1, SOF_TXD,  8'h01,    1'b1, 16'd1);
    add_row(1'b0, ABORT_TXD, 8'hFF,   1'b0, ABORT_TXD, 8'hFF,   1'b1, 16'd2);
    add_row(1'b0, IDLE_TXD, IDLE_TXC, 1'b0, IDLE_TXD, IDLE_TXC, 1'b1, 16'd2);
    add_row(1'b0, IDLE_TXD, IDLE_TXC, 1'b0, IDLE_TXD, IDLE_TXC, 1'b0, 16'd2);

    sys_rst = 1'b1;
    s0_req  = 1'b0;
    s1_req  = 1'b0;
    en      = 2'b11;
    set_src(0, JUNK_TXD, 8'h00);
    set_src(1, JUNK_TXD, 8'h00);
    step();
    check_output("rst_txd", xgmii_txd, IDLE_TXD);
    check_output("rst_txc", 64'(xgmii_txc), 64'(IDLE_TXC));
    check_output("rst_gnt", 64'({s0_gnt, s1_gnt}), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_cnts", {24'd0, frame_cnt0, frame_cnt1, abort_cnt}, 64'd0);
    do_reset();

    for (int i = 0; i < vec_q.size(); i++) begin
      s0_req = vec_q[i].req0;
      set_src(0, vec_q[i].d0, vec_q[i].c0);
      step();
      check_output($sformatf("row%0d_txd", i), xgmii_txd, vec_q[i].etxd);
      check_output($sformatf("row%0d_txc", i), 64'(xgmii_txc), 64'(vec_q[i].etxc));
      check_output($sformatf("row%0d_gnt", i), 64'({s0_gnt, s1_gnt}), 64'({vec_q[i].egnt0, 1'b0}));
      check_output($sformatf("row%0d_busy", i), 64'(busy), 64'(vec_q[i].ebusy));
      check_output($sformatf("row%0d_fc0", i), 64'(frame_cnt0), 64'(vec_q[i].efc0));
    end

    do_reset();
    s0_req = 1'b1;
    s1_req = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_grant(who);
      check_output($sformatf("cont_order%0d", f), 64'(who), 64'(f % 2));
      if (who >= 0) apply_stimulus(who, 3);
    end
    s0_req = 1'b0;
    s1_req = 1'b0;
    check_output("cont_fc0", 64'(frame_cnt0), 64'd2);
    check_output("cont_fc1", 64'(frame_cnt1), 64'd2);

    do_reset();
    en = 2'b10;
    s0_req = 1'b1;
    s1_req = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_grant(who);
      check_output($sformatf("mask_gnt%0d", f), 64'(who), 64'd1);
      if (who >= 0) apply_stimulus(who, 2);
    end
    s0_req = 1'b0;
    s1_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_output("mask_fc0", 64'(frame_cnt0), 64'd0);
    check_output("mask_fc1", 64'(frame_cnt1), 64'd2);

    do_reset();
    s0_req = 1'b1;
    set_src(0, JUNK_TXD, 8'h00);
    wait_grant(who);
    check_output("tmo_first", 64'(who), 64'd0);
    s1_req = 1'b1;
    hi = (who == 0) ? 1 : 0;
    idle_ok = 1'b1;
    for (int i = 0; i < 40 && s0_gnt; i++) begin
      step();
      if (xgmii_txc !== IDLE_TXC || xgmii_txd !== IDLE_TXD) idle_ok = 1'b0;
      if (s0_gnt) hi++;
    end
    check_output("tmo_gnt_cycles", 64'(hi), 64'd16);
    check_output("tmo_idle_out", 64'(idle_ok), 64'd1);
    wait_grant(who);
    check_output("tmo_next", 64'(who), 64'd1);
    s0_req = 1'b0;
    s1_req = 1'b0;
    set_src(0, IDLE_TXD, IDLE_TXC);
    if (who >= 0) apply_stimulus(who, 1);

    do_reset();
    s1_req = 1'b1;
    wait_grant(who);
    check_output("run_gnt", 64'(who), 64'd1);
    s1_req = 1'b0;
    set_src(1, SOF_TXD, 8'h01);
    step();
    check_output("run_sof", xgmii_txd, SOF_TXD);
    set_src(1, RUN_TXD, 8'h00);
    for (int n = 2; n <= 190; n++) begin
      step();
      if (n == 189) check_output("run_w189", xgmii_txd, RUN_TXD);
    end
    check_output("run_abort_txd", xgmii_txd, ABORT_TXD);
    check_output("run_abort_txc", 64'(xgmii_txc), 64'hFF);
    check_output("run_abort_cnt", 64'(abort_cnt), 64'd1);
    check_output("run_fc1", 64'(frame_cnt1), 64'd0);
    check_output("run_gnt_drop", 64'(s1_gnt), 64'd0);
    set_src(1, IDLE_TXD, IDLE_TXC);

    s0_req = 1'b1;
    wait_grant(who);
    s0_req = 1'b0;
    if (who >= 0) apply_stimulus(who, 2);
    check_output("rsend_fc0_pre", 64'(frame_cnt0), 64'd1);
    s0_req = 1'b1;
    wait_grant(who);
    check_output("rsend_gnt", 64'(who), 64'd0);
    s0_req = 1'b0;
    set_src(0, SOF_TXD, 8'h01);
    step();
    set_src(0, RUN_TXD, 8'h00);
    step();
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check_output("rsend_txd", xgmii_txd, IDLE_TXD);
    check_output("rsend_txc", 64'(xgmii_txc), 64'(IDLE_TXC));
    check_output("rsend_gnt_low", 64'({s0_gnt, s1_gnt}), 64'd0);
    check_output("rsend_busy", 64'(busy), 64'd0);
    check_output("rsend_cnts", {24'd0, frame_cnt0, frame_cnt1, abort_cnt}, 64'd0);
    set_src(0, IDLE_TXD, IDLE_TXC);
    s0_req = 1'b1;
    s1_req = 1'b1;
    wait_grant(who);
    check_output("rsend_tie", 64'(who), 64'd0);
    s0_req = 1'b0;
    s1_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
